// File: rtl/fsm_rom_sched.sv
// fsm_rom_sched: round-robin scheduler that time-shares one 16x6 transition
// table among N_CH independent 3-bit FSM channels. Each cycle at most one
// requesting channel is granted, looked up at {a, state} and advanced.
// Table word = {next[2:0], out[2:0]}.
// Optional feature macro: CFG_WR_EN (writable table, cfg_* ports present).
module fsm_rom_sched #(
    parameter int         N_CH        = 4,
    parameter int         CW          = $clog2(N_CH),
    parameter logic [2:0] RESET_STATE = 3'd2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_CH-1:0]     req,
    input  logic [N_CH-1:0]     a_in,
    output logic [N_CH-1:0]     gnt,
    output logic                out_vld,
    output logic [CW-1:0]       out_ch,
    output logic [2:0]          out_code,
`ifdef CFG_WR_EN
    output logic [3*N_CH-1:0]   state_bus,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_addr,
    input  logic [5:0]          cfg_data
`else
    output logic [3*N_CH-1:0]   state_bus
`endif
);

    // Default transition table: out mirrors the current state; unused
    // states fall back to state 2 so a corrupted channel recovers.
    function automatic logic [5:0] default_word(input logic [3:0] addr);
        logic       a;
        logic [2:0] s;
        logic [2:0] nxt;
        a = addr[3];
        s = addr[2:0];
        case (s)
            3'd1:    nxt = 3'd6;
            3'd2:    nxt = 3'd4;
            3'd4:    nxt = a ? 3'd1 : 3'd6;
            3'd6:    nxt = 3'd7;
            3'd7:    nxt = a ? 3'd4 : 3'd2;
            default: nxt = 3'd2;
        endcase
        return {nxt, s};
    endfunction

    logic [N_CH-1:0][2:0] state_q, state_d;
    logic [CW-1:0]        ptr_q, ptr_d;
    logic                 out_vld_q, out_vld_d;
    logic [CW-1:0]        out_ch_q, out_ch_d;
    logic [2:0]           out_code_q, out_code_d;

    logic                 gnt_any;
    logic [CW-1:0]        gnt_idx;
    logic                 arb_hit;
    logic [CW-1:0]        arb_idx;
    logic [3:0]           lk_addr;
    logic [5:0]           lk_word;
    logic                 wr_blk;

`ifdef CFG_WR_EN
    logic [5:0] tbl_q [16];
    logic [5:0] tbl_d [16];

    assign wr_blk  = cfg_we;
    assign lk_word = tbl_q[lk_addr];

    // Table write port: a write lands at the edge, visible from next cycle.
    always_comb begin
        tbl_d = tbl_q;
        if (cfg_we) tbl_d[cfg_addr] = cfg_data;
    end

    // Table register array, reloaded with the default contents on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) tbl_q[i] <= default_word(4'(i));
        end else begin
            tbl_q <= tbl_d;
        end
    end
`else
    assign wr_blk  = 1'b0;
    assign lk_word = default_word(lk_addr);
`endif

    // Round-robin search starting at the pointer, wrapping modulo N_CH.
    always_comb begin
        int j;
        j       = 0;
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N_CH) j = j - N_CH;
            if (!arb_hit && req[j]) begin
                arb_hit = 1'b1;
                arb_idx = CW'(j);
            end
        end
    end

    // A table write takes the cycle: no grant, no lookup.
    assign gnt_any = arb_hit && !wr_blk;
    assign gnt_idx = arb_idx;
    assign gnt     = gnt_any ? (N_CH'(1) << gnt_idx) : '0;
    assign lk_addr = {a_in[gnt_idx], state_q[gnt_idx]};

    // Advance the granted channel and stage the lookup result.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_vld_d  = 1'b0;
        out_ch_d   = out_ch_q;
        out_code_d = out_code_q;
        if (gnt_any) begin
            state_d[gnt_idx] = lk_word[5:3];
            ptr_d            = (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + CW'(1);
            out_vld_d        = 1'b1;
            out_ch_d         = gnt_idx;
            out_code_d       = lk_word[2:0];
        end
    end

    // Channel states, pointer and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < N_CH; k++) state_q[k] <= RESET_STATE;
            ptr_q      <= '0;
            out_vld_q  <= 1'b0;
            out_ch_q   <= '0;
            out_code_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_vld_q  <= out_vld_d;
            out_ch_q   <= out_ch_d;
            out_code_q <= out_code_d;
        end
    end

    assign out_vld   = out_vld_q;
    assign out_ch    = out_ch_q;
    assign out_code  = out_code_q;
    assign state_bus = state_q;

endmodule

// File: tb/tb_fsm_rom_sched.sv
// Directed bench for fsm_rom_sched (4 channels, default table).
module tb_fsm_rom_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  a_in;
    logic [3:0]  gnt;
    logic        out_vld;
    logic [1:0]  out_ch;
    logic [2:0]  out_code;
    logic [11:0] state_bus;
`ifdef CFG_WR_EN
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [5:0]  cfg_data;
`endif

    int n_tests;
    int n_fail;

    fsm_rom_sched #(.N_CH(4), .CW(2), .RESET_STATE(3'd2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_in      (a_in),
        .gnt       (gnt),
        .out_vld   (out_vld),
        .out_ch    (out_ch),
        .out_code  (out_code),
`ifdef CFG_WR_EN
        .state_bus (state_bus),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
`else
        .state_bus (state_bus)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        a_in  = '0;
`ifdef CFG_WR_EN
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
`endif
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (out_vld !== 1'b0 || out_ch !== 2'd0 || out_code !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outs: vld=%b ch=%0d code=%0d, want 0/0/0", out_vld, out_ch, out_code);
        end
        n_tests++;
        if (state_bus !== 12'h492) begin
            n_fail++;
            $display("FAIL reset_states: got %h want 492", state_bus);
        end
        n_tests++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_nogrant: got %b want 0000", gnt);
        end
    endtask

    task automatic run_single(input logic a, input logic [2:0] e0, input logic [2:0] e1,
                              input logic [2:0] e2, input logic [2:0] e3, input logic [2:0] e4,
                              input string nm);
        logic [2:0] exp [5];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3; exp[4] = e4;
        do_reset();
        req = 4'b0001;
        a_in = {3'b000, a};
        #1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (gnt !== 4'b0001) begin
                n_fail++;
                $display("FAIL %s_gnt[%0d]: got %b want 0001", nm, i, gnt);
            end
            tick();
            n_tests++;
            if (out_vld !== 1'b1 || out_ch !== 2'd0 || out_code !== exp[i]) begin
                n_fail++;
                $display("FAIL %s_out[%0d]: vld=%b ch=%0d code=%0d, want 1/0/%0d",
                         nm, i, out_vld, out_ch, out_code, exp[i]);
            end
        end
        n_tests++;
        if (state_bus[2:0] !== 3'd4) begin
            n_fail++;
            $display("FAIL %s_final_state: got %0d want 4", nm, state_bus[2:0]);
        end
        // Idle cycle: valid drops, result fields hold.
        req = '0;
        tick();
        n_tests++;
        if (out_vld !== 1'b0 || out_code !== exp[4] || out_ch !== 2'd0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s_idle: vld=%b code=%0d ch=%0d gnt=%b, want 0/%0d/0/0000",
                     nm, out_vld, out_code, out_ch, gnt, exp[4]);
        end
    endtask

    task automatic test_seq_a0();
        run_single(1'b0, 3'd2, 3'd4, 3'd6, 3'd7, 3'd2, "seq_a0");
    endtask

    task automatic test_seq_a1();
        run_single(1'b1, 3'd2, 3'd4, 3'd1, 3'd6, 3'd7, "seq_a1");
    endtask

    task automatic test_round_robin();
        logic [3:0] eg [5];
        logic [1:0] ec [5];
        eg[0] = 4'b0001; eg[1] = 4'b0010; eg[2] = 4'b0100; eg[3] = 4'b1000; eg[4] = 4'b0001;
        ec[0] = 2'd0; ec[1] = 2'd1; ec[2] = 2'd2; ec[3] = 2'd3; ec[4] = 2'd0;
        do_reset();
        req = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (gnt !== eg[i]) begin
                n_fail++;
                $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, eg[i]);
            end
            tick();
            n_tests++;
            if (out_vld !== 1'b1 || out_ch !== ec[i]) begin
                n_fail++;
                $display("FAIL rr_out[%0d]: vld=%b ch=%0d want 1/%0d", i, out_vld, out_ch, ec[i]);
            end
        end
        // ch0 advanced twice (2->4->6), others once (2->4).
        n_tests++;
        if (state_bus !== 12'h926) begin
            n_fail++;
            $display("FAIL rr_states: got %h want 926", state_bus);
        end
        req = '0;
    endtask

    task automatic test_alternate();
        logic [3:0] eg [4];
        eg[0] = 4'b0001; eg[1] = 4'b0100; eg[2] = 4'b0001; eg[3] = 4'b0100;
        do_reset();
        req = 4'b0101;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (gnt !== eg[i]) begin
                n_fail++;
                $display("FAIL alt_gnt[%0d]: got %b want %b", i, gnt, eg[i]);
            end
            tick();
        end
        n_tests++;
        if (state_bus[5:3] !== 3'd2 || state_bus[11:9] !== 3'd2) begin
            n_fail++;
            $display("FAIL alt_idle_states: ch1=%0d ch3=%0d want 2/2", state_bus[5:3], state_bus[11:9]);
        end
        // ch0 and ch2 each advanced twice: 2->4->6.
        n_tests++;
        if (state_bus[2:0] !== 3'd6 || state_bus[8:6] !== 3'd6) begin
            n_fail++;
            $display("FAIL alt_busy_states: ch0=%0d ch2=%0d want 6/6", state_bus[2:0], state_bus[8:6]);
        end
        req = '0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b1111;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if (out_vld !== 1'b0 || out_ch !== 2'd0 || out_code !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_outs: vld=%b ch=%0d code=%0d want 0/0/0", out_vld, out_ch, out_code);
        end
        n_tests++;
        if (state_bus !== 12'h492) begin
            n_fail++;
            $display("FAIL midrst_states: got %h want 492", state_bus);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_ptr: gnt=%b want 0001", gnt);
        end
        req = '0;
    endtask

`ifdef CFG_WR_EN
    task automatic test_cfg_write();
        do_reset();
        req      = 4'b0001;
        cfg_we   = 1'b1;
        cfg_addr = 4'h2;
        cfg_data = 6'o12;
        #1;
        n_tests++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL cfg_gnt_blocked: got %b want 0000", gnt);
        end
        tick();
        cfg_we = 1'b0;
        n_tests++;
        if (out_vld !== 1'b0 || state_bus[2:0] !== 3'd2) begin
            n_fail++;
            $display("FAIL cfg_wr_cycle: vld=%b st0=%0d want 0/2", out_vld, state_bus[2:0]);
        end
        tick();
        n_tests++;
        if (out_vld !== 1'b1 || out_code !== 3'd2 || state_bus[2:0] !== 3'd1) begin
            n_fail++;
            $display("FAIL cfg_lk1: vld=%b code=%0d st0=%0d want 1/2/1", out_vld, out_code, state_bus[2:0]);
        end
        tick();
        n_tests++;
        if (out_vld !== 1'b1 || out_code !== 3'd1 || state_bus[2:0] !== 3'd6) begin
            n_fail++;
            $display("FAIL cfg_lk2: vld=%b code=%0d st0=%0d want 1/1/6", out_vld, out_code, state_bus[2:0]);
        end
        req = '0;
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        req     = '0;
        a_in    = '0;
`ifdef CFG_WR_EN
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
`endif
        test_reset();
        test_seq_a0();
        test_seq_a1();
        test_round_robin();
        test_alternate();
        test_mid_reset();
`ifdef CFG_WR_EN
        test_cfg_write();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
